reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/y86_arf_pkg.sv | 44 ++++
 rtl/wb_en_reg.sv | 24 ++
 rtl/wb_starve_counter.sv | 33 +++
 rtl/reg_wb_arbiter.sv | 111 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_arf_pkg.sv
// Shared Y86 architectural register file definitions: register ids, widths
// and the write-port payload used by the write-back arbiter.
package y86_arf_pkg;

  localparam int GPR_W   = 32;
  localparam int ID_W    = 4;
  localparam int NUM_GPR = 8;

  typedef logic [ID_W-1:0]  reg_id_t;
  typedef logic [GPR_W-1:0] gpr_val_t;

  localparam reg_id_t ID_EAX     = 4'h0;
  localparam reg_id_t ID_ECX     = 4'h1;
  localparam reg_id_t ID_EDX     = 4'h2;
  localparam reg_id_t ID_EBX     = 4'h3;
  localparam reg_id_t ID_ESP     = 4'h4;
  localparam reg_id_t ID_EBP     = 4'h5;
  localparam reg_id_t ID_ESI     = 4'h6;
  localparam reg_id_t ID_EDI     = 4'h7;
  localparam reg_id_t ID_INVALID = 4'hF;

  // One ARF write port: destination id plus value.
  typedef struct packed {
    reg_id_t  id;
    gpr_val_t val;
  } arf_wr_t;

  // An idle port drives the invalid id and a zero value.
  localparam arf_wr_t ARF_WR_IDLE = '{id: ID_INVALID, val: '0};

  // Ids 0..7 name a real GPR; 8..F are "no register" encodings.
  function automatic logic id_is_gpr(reg_id_t id);
    return !id[ID_W-1];
  endfunction

  // One-hot GPR mask for an id; zero for non-GPR ids.
  function automatic logic [NUM_GPR-1:0] id_onehot(reg_id_t id);
    logic [NUM_GPR-1:0] m;
    m = '0;
    if (id_is_gpr(id)) m[id[2:0]] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_en_reg.sv
// Generic enabled register with asynchronous active-low clear to a
// parameterised reset value.
module wb_en_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Capture d when enabled; clear immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   q_q <= RST_VAL;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/wb_starve_counter.sv
// Saturating starvation counter: counts refused cycles of a requester and
// flags when the count reaches LIMIT.
module wb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int            CW  = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority; otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && cnt_q < LIM) cnt_d = cnt_q + 1'b1;
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the Y86 ARF: merges execute, memory and (optionally)
// debug write requests onto the calc and memory ARF write ports.
// Optional feature macro: REG_WB_DEBUG_PORT_EN adds the debug request port,
// its starvation counter and the DBG_STARVE_LIMIT parameter.
module reg_wb_arbiter
  import y86_arf_pkg::*;
`ifdef REG_WB_DEBUG_PORT_EN
#(
  parameter int DBG_STARVE_LIMIT = 4
)
`endif
(
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 ExValid,
  output logic                 ExReady,
  input  logic [ID_W-1:0]      ExReg,
  input  logic [GPR_W-1:0]     ExVal,
  input  logic                 MmValid,
  output logic                 MmReady,
  input  logic [ID_W-1:0]      MmReg,
  input  logic [GPR_W-1:0]     MmVal,
`ifdef REG_WB_DEBUG_PORT_EN
  input  logic                 DbgValid,
  output logic                 DbgReady,
  input  logic [ID_W-1:0]      DbgReg,
  input  logic [GPR_W-1:0]     DbgVal,
`endif
  output logic [ID_W-1:0]      CalcValcReg,
  output logic [GPR_W-1:0]     CalcVal,
  output logic [ID_W-1:0]      MemValReg,
  output logic [GPR_W-1:0]     MemVal,
  output logic [NUM_GPR-1:0]   PendingMask
);

  logic ex_clash;      // Ex and Mm target the same GPR this cycle
  logic ex_force_off;  // debug has taken priority over Ex
  logic ex_take;       // Ex accepted and needs the calc port
  logic mm_take;       // Mm accepted and needs the memory port

  arf_wr_t            calc_d, mem_d, calc_q, mem_q;
  logic [NUM_GPR-1:0] mask_d, mask_q;

  // Mm is never refused; on a same-GPR clash Ex waits a cycle so the younger
  // Ex value is written last.
  assign ex_clash = MmValid && id_is_gpr(MmReg) && id_is_gpr(ExReg) && (ExReg == MmReg);
  assign MmReady  = ResetN;
  assign ExReady  = ResetN && !ex_clash && !ex_force_off;
  assign mm_take  = MmValid && MmReady && id_is_gpr(MmReg);
  assign ex_take  = ExValid && ExReady && id_is_gpr(ExReg);

`ifdef REG_WB_DEBUG_PORT_EN
  logic    dbg_at_limit, dbg_blocked, dbg_take;
  arf_wr_t dbg_wr;

  // Debug needs a free port and an id distinct from every other grant.
  assign dbg_blocked  = (mm_take && ex_take) ||
                        (mm_take && (DbgReg == MmReg)) ||
                        (ex_take && (DbgReg == ExReg));
  assign DbgReady     = ResetN && (!id_is_gpr(DbgReg) || !dbg_blocked);
  assign dbg_take     = DbgValid && DbgReady && id_is_gpr(DbgReg);
  assign ex_force_off = DbgValid && dbg_at_limit;
  assign dbg_wr       = '{id: DbgReg, val: DbgVal};

  wb_starve_counter #(
    .LIMIT (DBG_STARVE_LIMIT)
  ) u_starve (
    .clk_i      (Clock),
    .rst_ni     (ResetN),
    .inc_i      (DbgValid && !DbgReady),
    .clr_i      (!DbgValid || DbgReady),
    .at_limit_o (dbg_at_limit)
  );
`else
  assign ex_force_off = 1'b0;
`endif

  // Route grants to ports: Mm -> memory, Ex -> calc, debug -> whichever is free.
  always_comb begin
    calc_d = ARF_WR_IDLE;
    mem_d  = ARF_WR_IDLE;
    if (mm_take) mem_d  = '{id: MmReg, val: MmVal};
    if (ex_take) calc_d = '{id: ExReg, val: ExVal};
`ifdef REG_WB_DEBUG_PORT_EN
    if (dbg_take) begin
      if (!mm_take) mem_d  = dbg_wr;
      else          calc_d = dbg_wr;
    end
`endif
    mask_d = id_onehot(calc_d.id) | id_onehot(mem_d.id);
  end

  wb_en_reg #(.W($bits(arf_wr_t)), .RST_VAL(ARF_WR_IDLE)) u_calc_reg (
    .clk_i (Clock), .rst_ni (ResetN), .en_i (1'b1), .d_i (calc_d), .q_o (calc_q)
  );

  wb_en_reg #(.W($bits(arf_wr_t)), .RST_VAL(ARF_WR_IDLE)) u_mem_reg (
    .clk_i (Clock), .rst_ni (ResetN), .en_i (1'b1), .d_i (mem_d), .q_o (mem_q)
  );

  wb_en_reg #(.W(NUM_GPR), .RST_VAL('0)) u_mask_reg (
    .clk_i (Clock), .rst_ni (ResetN), .en_i (1'b1), .d_i (mask_d), .q_o (mask_q)
  );

  assign CalcValcReg = calc_q.id;
  assign CalcVal     = calc_q.val;
  assign MemValReg   = mem_q.id;
  assign MemVal      = mem_q.val;
  assign PendingMask = mask_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus randomized Ex/Mm traffic
// checked against a register-file level reference model.
module tb_reg_wb_arbiter;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        ExValid = 1'b0, MmValid = 1'b0;
  logic [3:0]  ExReg = 4'hF, MmReg = 4'hF;
  logic [31:0] ExVal = '0, MmVal = '0;
  logic        ExReady, MmReady;
  logic [3:0]  CalcValcReg, MemValReg;
  logic [31:0] CalcVal, MemVal;
  logic [7:0]  PendingMask;
`ifdef REG_WB_DEBUG_PORT_EN
  logic        DbgValid = 1'b0;
  logic [3:0]  DbgReg = 4'hF;
  logic [31:0] DbgVal = '0;
  logic        DbgReady;
`endif

  int tests = 0;
  int fails = 0;

  // Expected port contents and register files (reference vs. observed ARF).
  logic [3:0]  exp_cid = 4'hF, exp_mid = 4'hF;
  logic [31:0] exp_cval = '0, exp_mval = '0;
  logic [31:0] ref_arf [8];
  logic [31:0] obs_arf [8];

  reg_wb_arbiter dut (
    .Clock       (Clock),
    .ResetN      (ResetN),
    .ExValid     (ExValid),
    .ExReady     (ExReady),
    .ExReg       (ExReg),
    .ExVal       (ExVal),
    .MmValid     (MmValid),
    .MmReady     (MmReady),
    .MmReg       (MmReg),
    .MmVal       (MmVal),
`ifdef REG_WB_DEBUG_PORT_EN
    .DbgValid    (DbgValid),
    .DbgReady    (DbgReady),
    .DbgReg      (DbgReg),
    .DbgVal      (DbgVal),
`endif
    .CalcValcReg (CalcValcReg),
    .CalcVal     (CalcVal),
    .MemValReg   (MemValReg),
    .MemVal      (MemVal),
    .PendingMask (PendingMask)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mask_of(input logic [3:0] id);
    return (id < 4'd8) ? (8'b1 << id) : 8'h00;
  endfunction

  // One clock cycle with the inputs already driven (entered just after a
  // negedge): predicts readiness and next-cycle port contents from the rules,
  // updates both register files, then checks the ports after the edge.
  task automatic step(output bit ex_acc);
    logic exp_ex_rdy;
    #1;
    if (CalcValcReg < 4'd8) obs_arf[CalcValcReg[2:0]] = CalcVal;
    if (MemValReg < 4'd8)   obs_arf[MemValReg[2:0]]   = MemVal;
    exp_ex_rdy = !(MmValid && (MmReg < 4'd8) && (ExReg < 4'd8) && (ExReg == MmReg));
    chk("MmReady", 32'(MmReady), 32'(1'b1));
    chk("ExReady", 32'(ExReady), 32'(exp_ex_rdy));
    ex_acc = ExValid && exp_ex_rdy;
    exp_mid = 4'hF; exp_mval = '0; exp_cid = 4'hF; exp_cval = '0;
    if (MmValid && MmReg < 4'd8) begin
      ref_arf[MmReg[2:0]] = MmVal;
      exp_mid = MmReg; exp_mval = MmVal;
    end
    if (ex_acc && ExReg < 4'd8) begin
      ref_arf[ExReg[2:0]] = ExVal;
      exp_cid = ExReg; exp_cval = ExVal;
    end
    @(posedge Clock);
    #1;
    chk("CalcReg", 32'(CalcValcReg), 32'(exp_cid));
    chk("CalcVal", CalcVal, exp_cval);
    chk("MemReg", 32'(MemValReg), 32'(exp_mid));
    chk("MemVal", MemVal, exp_mval);
    chk("PendingMask", 32'(PendingMask), 32'(mask_of(exp_cid) | mask_of(exp_mid)));
    @(negedge Clock);
  endtask

  initial begin
    bit          acc;
    logic [31:0] esi_saved, edi_saved;
    acc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ref_arf[i] = '0;
      obs_arf[i] = '0;
    end

    // Reset state, with requests presented while reset is held.
    ExValid = 1'b1; ExReg = 4'd1; MmValid = 1'b1; MmReg = 4'd2;
    repeat (2) @(negedge Clock);
    #1;
    chk("rst CalcReg", 32'(CalcValcReg), 32'hF);
    chk("rst CalcVal", CalcVal, 32'h0);
    chk("rst MemReg", 32'(MemValReg), 32'hF);
    chk("rst MemVal", MemVal, 32'h0);
    chk("rst Mask", 32'(PendingMask), 32'h0);
    chk("rst ExReady", 32'(ExReady), 32'h0);
    chk("rst MmReady", 32'(MmReady), 32'h0);
    @(negedge Clock);
    ExValid = 1'b0; MmValid = 1'b0;
    ResetN = 1'b1;

    // Independent Ex and Mm writes granted together.
    ExValid = 1'b1; ExReg = 4'd1; ExVal = 32'h11;
    MmValid = 1'b1; MmReg = 4'd2; MmVal = 32'h22;
    step(acc);
    chk("dual CalcReg", 32'(CalcValcReg), 32'h1);
    chk("dual CalcVal", CalcVal, 32'h11);
    chk("dual MemReg", 32'(MemValReg), 32'h2);
    chk("dual MemVal", MemVal, 32'h22);
    chk("dual Mask", 32'(PendingMask), 32'h06);

    // Same register: Mm first, Ex one cycle later so EBX ends with Ex value.
    ExReg = 4'd3; ExVal = 32'hAA; MmReg = 4'd3; MmVal = 32'hBB;
    step(acc);
    chk("clash ExAcc", 32'(acc), 32'h0);
    chk("clash MemReg", 32'(MemValReg), 32'h3);
    chk("clash MemVal", MemVal, 32'hBB);
    chk("clash CalcReg", 32'(CalcValcReg), 32'hF);
    MmValid = 1'b0;
    step(acc);
    chk("clash2 CalcReg", 32'(CalcValcReg), 32'h3);
    chk("clash2 CalcVal", CalcVal, 32'hAA);
    ExValid = 1'b0;
    step(acc);
    chk("clash EBX final", obs_arf[3], 32'hAA);

    // Non-GPR id is accepted immediately and drives no port.
    ExValid = 1'b1; ExReg = 4'hF; ExVal = 32'h1234;
    #1;
    chk("inv ExReady", 32'(ExReady), 32'h1);
    @(negedge Clock);
    step(acc);
    chk("inv CalcReg", 32'(CalcValcReg), 32'hF);
    chk("inv MemReg", 32'(MemValReg), 32'hF);
    chk("inv Mask", 32'(PendingMask), 32'h0);
    ExValid = 1'b0;

    // Randomized traffic; a refused Ex request holds its payload.
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!ExValid || acc) begin
        ExValid = 1'($urandom_range(0, 1));
        ExReg   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 3));
        ExVal   = $urandom;
      end
      MmValid = 1'($urandom_range(0, 1));
      MmReg   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 3));
      MmVal   = $urandom;
      step(acc);
    end
    ExValid = 1'b0; MmValid = 1'b0;
    step(acc);
    step(acc);
    for (int i = 0; i < 8; i++) chk($sformatf("arf[%0d]", i), obs_arf[i], ref_arf[i]);

    // Reset while an accepted Ex write sits on the port: it must be dropped.
    esi_saved = obs_arf[6];
    edi_saved = obs_arf[7];
    ExValid = 1'b1; ExReg = 4'd6; ExVal = 32'h6666_0006;
    step(acc);
    chk("inflt CalcReg", 32'(CalcValcReg), 32'h6);
    ExValid = 1'b0;
    #2;
    ResetN = 1'b0;
    #1;
    chk("inflt rst CalcReg", 32'(CalcValcReg), 32'hF);
    chk("inflt rst CalcVal", CalcVal, 32'h0);
    chk("inflt rst Mask", 32'(PendingMask), 32'h0);
    chk("inflt rst ExReady", 32'(ExReady), 32'h0);
    exp_cid = 4'hF; exp_cval = '0; exp_mid = 4'hF; exp_mval = '0;
    @(negedge Clock);
    ResetN = 1'b1;
    step(acc);
    step(acc);
    chk("inflt ESI kept", obs_arf[6], esi_saved);
    chk("inflt EDI kept", obs_arf[7], edi_saved);

`ifdef REG_WB_DEBUG_PORT_EN
    // Debug takes the free memory port alongside Ex.
    ExValid = 1'b1; ExReg = 4'd2; ExVal = 32'h202;
    MmValid = 1'b0;
    DbgValid = 1'b1; DbgReg = 4'd4; DbgVal = 32'h404;
    #1;
    chk("dbg free DbgReady", 32'(DbgReady), 32'h1);
    chk("dbg free ExReady", 32'(ExReady), 32'h1);
    @(posedge Clock);
    #1;
    chk("dbg free MemReg", 32'(MemValReg), 32'h4);
    chk("dbg free MemVal", MemVal, 32'h404);
    chk("dbg free CalcReg", 32'(CalcValcReg), 32'h2);
    chk("dbg free Mask", 32'(PendingMask), 32'h14);
    @(negedge Clock);

    // Both ports busy every cycle: debug forced through on the fifth cycle.
    ExReg = 4'd0; ExVal = 32'hE0; MmValid = 1'b1; MmReg = 4'd1; MmVal = 32'hD1;
    DbgReg = 4'd5; DbgVal = 32'h55;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("starve%0d DbgReady", k), 32'(DbgReady), 32'h0);
      chk($sformatf("starve%0d ExReady", k), 32'(ExReady), 32'h1);
      @(negedge Clock);
    end
    #1;
    chk("forced DbgReady", 32'(DbgReady), 32'h1);
    chk("forced ExReady", 32'(ExReady), 32'h0);
    chk("forced MmReady", 32'(MmReady), 32'h1);
    @(posedge Clock);
    #1;
    chk("forced CalcReg", 32'(CalcValcReg), 32'h5);
    chk("forced CalcVal", CalcVal, 32'h55);
    chk("forced MemReg", 32'(MemValReg), 32'h1);
    @(negedge Clock);

    // Forced debug colliding with Mm's register keeps waiting at the limit.
    DbgReg = 4'd1; DbgVal = 32'h77;
    for (int k = 1; k <= 7; k++) begin
      #1;
      chk($sformatf("hold%0d DbgReady", k), 32'(DbgReady), 32'h0);
      chk($sformatf("hold%0d ExReady", k), 32'(ExReady), (k >= 5) ? 32'h0 : 32'h1);
      @(negedge Clock);
    end
    DbgValid = 1'b0;
    @(negedge Clock);
    #1;
    chk("release ExReady", 32'(ExReady), 32'h1);
    @(negedge Clock);
    ExValid = 1'b0; MmValid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
